pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of each performance counter.
REQ-002 Parameter DELAY_SLOT, default 1; 1 = the instruction after a taken branch executes, 0 = it is squashed.
REQ-003 Parameter DRAIN_CYCLES, default 3, number of bubble cycles that empty DEC/EX/MEM/WB before HALTED.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 dec_valid  in  1  DEC stage holds a real instruction.
REQ-007 dec_rn, dec_rm  in  5 each  DEC source register addresses; for STUR/CBZ dec_rm carries Rd.
REQ-008 dec_rn_used, dec_rm_used  in  1 each  corresponding source is actually read.
REQ-009 dec_br_taken  in  1  raw BrTaken from decode.
REQ-010 ex_load, ex_regwrite  in  1 each  EX instruction is LDUR / writes a register.
REQ-011 ex_aw  in  5  EX destination register.
REQ-012 halt_req, resume  in  1 each  single-cycle pulses.
REQ-013 pc_en, ifdec_en  out  1 each  PC and IF/DEC register write enables.
REQ-014 ifdec_flush  out  1  IF/DEC register loads a NOP next edge.
REQ-015 decex_bubble  out  1  DEC/EX register loads zero control (RegWrite/MemWrite/flag_wr_en = 0).
REQ-016 br_taken_q  out  1  gated BrTaken delivered to IF.
REQ-017 halted  out  1  FSM in HALTED.
REQ-018 stall_cnt, flush_cnt, issue_cnt  out  CNT_W each  performance counters.

Function
REQ-019 Hazard (combinational) = dec_valid & ex_load & ex_regwrite & ex_aw != 31 & ((dec_rn_used & dec_rn == ex_aw) | (dec_rm_used & dec_rm == ex_aw)).
REQ-020 X31 never creates a hazard.
REQ-021 Only loads in EX stall; ALU results (EX) and load data (MEM) are forwarded by the datapath, so every hazard costs exactly 1 stall cycle.
REQ-022 States: RUN, DRAIN, HALTED.
REQ-023 RUN with hazard: pc_en = 0, ifdec_en = 0, decex_bubble = 1, br_taken_q = 0, in the same cycle.
REQ-024 A branch in DEC during a stall is not taken that cycle; it re-evaluates next cycle with forwarded data.
REQ-025 RUN, no hazard: pc_en = ifdec_en = 1, br_taken_q = dec_br_taken, decex_bubble = 0.
REQ-026 If DELAY_SLOT = 0 and br_taken_q = 1: ifdec_flush = 1 that cycle; if DELAY_SLOT = 1: ifdec_flush never asserts.
REQ-027 RUN + halt_req -> DRAIN: drain counter loads DRAIN_CYCLES-1; if a hazard coincides, the stall is honoured first and the transition occurs that same edge.
REQ-028 DRAIN: pc_en = 0, ifdec_en = 1, ifdec_flush = 1, br_taken_q = 0, decex_bubble = hazard; counter decrements each cycle; at 0 -> HALTED.
REQ-029 HALTED: pc_en = ifdec_en = 0, decex_bubble = 1, halted = 1; resume -> RUN next edge.
REQ-030 halt_req outside RUN and resume outside HALTED are ignored.
REQ-031 stall_cnt increments on each stall cycle (REQ-023).
REQ-032 flush_cnt increments on each ifdec_flush cycle.
REQ-033 issue_cnt increments when dec_valid & ~decex_bubble & state != HALTED.
REQ-034 All counters wrap modulo 2^CNT_W without saturation.

Reset
REQ-035 reset_n = 0 at an edge: state = RUN, drain counter = 0, all counters = 0.
REQ-036 While reset_n = 0: pc_en = ifdec_en = 1, flushes = 0, bubbles = 0, br_taken_q = 0, halted = 0.
REQ-037 Reset mid-DRAIN or in HALTED returns to RUN with no residual stall.

Structure
REQ-038 Shared package holds the state enum (RUN/DRAIN/HALTED) and the constant XZR = 5'd31.
REQ-039 One sub-module, hazard_detect, purely combinational and implementing REQ-019; the FSM and counters live in the top.

Verification
REQ-040 Load-use: EX = LDUR X2, DEC = ADD reading X2 -> one cycle with pc_en = 0, decex_bubble = 1, stall_cnt = 1; next cycle no stall.
REQ-041 X31: EX = LDUR writing X31, DEC reads X31 -> no stall, stall_cnt = 0.
REQ-042 Stall and branch: EX = LDUR X5, DEC = CBZ X5 with dec_br_taken = 1 -> br_taken_q = 0 in the stall cycle, = 1 in the next cycle.
REQ-043 DELAY_SLOT = 0, taken B -> ifdec_flush = 1 in that single cycle, flush_cnt = 1; DELAY_SLOT = 1 -> ifdec_flush = 0.
REQ-044 halt_req in RUN -> 3 DRAIN cycles (pc_en = 0), then halted = 1; resume -> RUN next edge, pc_en = 1.
REQ-045 reset_n = 0 during DRAIN -> next cycle state RUN, all counters 0, halted = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / halt controller.
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detect: a load in EX whose destination feeds a DEC source.
import pipe_hazard_ctrl_pkg::*;

module hazard_detect (
  input  logic       dec_valid,
  input  logic [4:0] dec_rn,
  input  logic [4:0] dec_rm,
  input  logic       dec_rn_used,
  input  logic       dec_rm_used,
  input  logic       ex_load,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_aw,
  output logic       hazard
);
  logic rn_hit, rm_hit;

  assign rn_hit = dec_rn_used & (dec_rn == ex_aw);
  assign rm_hit = dec_rm_used & (dec_rm == ex_aw);
  // XZR reads as zero, so a load targeting it never produces a dependency
  assign hazard = dec_valid & ex_load & ex_regwrite & (ex_aw != XZR) & (rn_hit | rm_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: one-cycle load-use stall, branch gating, halt drain FSM, perf counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DELAY_SLOT   = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rn,
  input  logic [4:0]       dec_rm,
  input  logic             dec_rn_used,
  input  logic             dec_rm_used,
  input  logic             dec_br_taken,
  input  logic             ex_load,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_aw,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifdec_en,
  output logic             ifdec_flush,
  output logic             decex_bubble,
  output logic             br_taken_q,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] issue_cnt
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          hazard;
  logic          stall;
  logic          issue;

  hazard_detect u_hazard_detect (
    .dec_valid   (dec_valid),
    .dec_rn      (dec_rn),
    .dec_rm      (dec_rm),
    .dec_rn_used (dec_rn_used),
    .dec_rm_used (dec_rm_used),
    .ex_load     (ex_load),
    .ex_regwrite (ex_regwrite),
    .ex_aw       (ex_aw),
    .hazard      (hazard)
  );

  // Reset forces a free-running pipe with no flush/bubble regardless of state
  always_comb begin
    pc_en        = 1'b1;
    ifdec_en     = 1'b1;
    ifdec_flush  = 1'b0;
    decex_bubble = 1'b0;
    br_taken_q   = 1'b0;
    halted       = 1'b0;
    if (reset_n) begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            pc_en        = 1'b0;
            ifdec_en     = 1'b0;
            decex_bubble = 1'b1;
          end else begin
            br_taken_q  = dec_br_taken;
            ifdec_flush = (DELAY_SLOT == 0) & dec_br_taken;
          end
        end
        DRAIN: begin
          pc_en        = 1'b0;
          ifdec_flush  = 1'b1;
          decex_bubble = hazard;
        end
        HALTED: begin
          pc_en        = 1'b0;
          ifdec_en     = 1'b0;
          decex_bubble = 1'b1;
          halted       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall = (state == RUN) & hazard;
  assign issue = dec_valid & ~decex_bubble & (state != HALTED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        RUN: if (halt_req) begin
          state     <= DRAIN;
          drain_cnt <= DW'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - DW'(1);
        end
        HALTED: if (resume) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall)       stall_cnt <= stall_cnt + CNT_ONE;
      if (ifdec_flush) flush_cnt <= flush_cnt + CNT_ONE;
      if (issue)       issue_cnt <= issue_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: a delay-slot DUT (32-bit counters) and a squash DUT (2-bit counters).
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, dec_valid, dec_rn_used, dec_rm_used, dec_br_taken;
  logic       ex_load, ex_regwrite, halt_req, resume;
  logic [4:0] dec_rn, dec_rm, ex_aw;

  logic        pc_en, ifdec_en, ifdec_flush, decex_bubble, br_taken_q, halted;
  logic [31:0] stall_cnt, flush_cnt, issue_cnt;
  logic        b_pc_en, b_ifdec_en, b_ifdec_flush, b_decex_bubble, b_br_taken_q, b_halted;
  logic [1:0]  b_stall_cnt, b_flush_cnt, b_issue_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32), .DELAY_SLOT(1), .DRAIN_CYCLES(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_rn_used(dec_rn_used), .dec_rm_used(dec_rm_used), .dec_br_taken(dec_br_taken),
    .ex_load(ex_load), .ex_regwrite(ex_regwrite), .ex_aw(ex_aw), .halt_req(halt_req),
    .resume(resume), .pc_en(pc_en), .ifdec_en(ifdec_en), .ifdec_flush(ifdec_flush),
    .decex_bubble(decex_bubble), .br_taken_q(br_taken_q), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .DELAY_SLOT(0), .DRAIN_CYCLES(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_rn_used(dec_rn_used), .dec_rm_used(dec_rm_used), .dec_br_taken(dec_br_taken),
    .ex_load(ex_load), .ex_regwrite(ex_regwrite), .ex_aw(ex_aw), .halt_req(halt_req),
    .resume(resume), .pc_en(b_pc_en), .ifdec_en(b_ifdec_en), .ifdec_flush(b_ifdec_flush),
    .decex_bubble(b_decex_bubble), .br_taken_q(b_br_taken_q), .halted(b_halted),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .issue_cnt(b_issue_cnt)
  );

  typedef struct {
    string tag;
    logic  pc, ie, fl, bu, br, ha, flb;
    int    stall, flush, issue, flush_b;
    bit    cnt_ok;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   e_stall = 0, e_flush = 0, e_issue = 0, e_flush_b = 0;
  bit   cnt_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the next edge, then applies DEC/EX inputs; control pulses default low
  task automatic drv(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                     input logic rnu, input logic rmu, input logic br,
                     input logic ld, input logic rw, input logic [4:0] aw);
    @(posedge clk); #1;
    dec_valid = v; dec_rn = rn; dec_rm = rm; dec_rn_used = rnu; dec_rm_used = rmu;
    dec_br_taken = br; ex_load = ld; ex_regwrite = rw; ex_aw = aw;
    halt_req = 1'b0; resume = 1'b0; reset_n = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic pc, input logic ie, input logic fl,
                     input logic bu, input logic br, input logic ha, input logic flb);
    exp_t e, g;
    e.tag = tag; e.pc = pc; e.ie = ie; e.fl = fl; e.bu = bu; e.br = br; e.ha = ha; e.flb = flb;
    e.stall = e_stall; e.flush = e_flush; e.issue = e_issue; e.flush_b = e_flush_b;
    e.cnt_ok = cnt_valid;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk({g.tag, ".pc_en"},        32'(pc_en),        32'(g.pc));
    chk({g.tag, ".ifdec_en"},     32'(ifdec_en),     32'(g.ie));
    chk({g.tag, ".ifdec_flush"},  32'(ifdec_flush),  32'(g.fl));
    chk({g.tag, ".decex_bubble"}, 32'(decex_bubble), 32'(g.bu));
    chk({g.tag, ".br_taken_q"},   32'(br_taken_q),   32'(g.br));
    chk({g.tag, ".halted"},       32'(halted),       32'(g.ha));
    chk({g.tag, ".b.ifdec_flush"},32'(b_ifdec_flush),32'(g.flb));
    chk({g.tag, ".b.pc_en"},      32'(b_pc_en),      32'(g.pc));
    if (g.cnt_ok) begin
      chk({g.tag, ".stall_cnt"},   stall_cnt,          32'(g.stall));
      chk({g.tag, ".flush_cnt"},   flush_cnt,          32'(g.flush));
      chk({g.tag, ".issue_cnt"},   issue_cnt,          32'(g.issue));
      chk({g.tag, ".b.stall_cnt"}, 32'(b_stall_cnt),   32'(g.stall % 4));
      chk({g.tag, ".b.flush_cnt"}, 32'(b_flush_cnt),   32'(g.flush_b % 4));
      chk({g.tag, ".b.issue_cnt"}, 32'(b_issue_cnt),   32'(g.issue % 4));
    end
    // Counter effect of this cycle, visible from the next cycle on
    if (!reset_n) begin
      e_stall = 0; e_flush = 0; e_issue = 0; e_flush_b = 0; cnt_valid = 1'b1;
    end else begin
      if (bu && !pc && !ie && !ha) e_stall++;
      if (fl)  e_flush++;
      if (flb) e_flush_b++;
      if (dec_valid && !bu && !ha) e_issue++;
    end
  endtask

  initial begin
    reset_n = 1'b0; dec_valid = 1'b0; dec_rn = '0; dec_rm = '0; dec_rn_used = 1'b0;
    dec_rm_used = 1'b0; dec_br_taken = 1'b0; ex_load = 1'b0; ex_regwrite = 1'b0;
    ex_aw = '0; halt_req = 1'b0; resume = 1'b0;

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); reset_n = 1'b0;
    cyc("rst0", 1, 1, 0, 0, 0, 0, 0);
    drv(1, 2, 0, 1, 0, 1, 1, 1, 2); reset_n = 1'b0;          // hazard+branch masked by reset
    cyc("rst_forced", 1, 1, 0, 0, 0, 0, 0);

    drv(1, 1, 3, 1, 1, 0, 0, 1, 1);  cyc("add_noload", 1, 1, 0, 0, 0, 0, 0);
    drv(1, 2, 0, 1, 0, 0, 1, 1, 2);  cyc("loaduse",    0, 0, 0, 1, 0, 0, 0);
    drv(1, 2, 0, 1, 0, 0, 0, 0, 2);  cyc("after_stall",1, 1, 0, 0, 0, 0, 0);
    drv(1, 31, 31, 1, 1, 0, 1, 1, 31); cyc("xzr",      1, 1, 0, 0, 0, 0, 0);
    drv(1, 0, 7, 1, 1, 0, 1, 1, 7);  cyc("rm_hazard",  0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 7, 1, 0, 0, 1, 1, 7);  cyc("rm_unused",  1, 1, 0, 0, 0, 0, 0);
    drv(1, 7, 0, 1, 0, 0, 1, 0, 7);  cyc("ld_no_wr",   1, 1, 0, 0, 0, 0, 0);
    drv(0, 7, 0, 1, 0, 0, 1, 1, 7);  cyc("dec_inval",  1, 1, 0, 0, 0, 0, 0);
    drv(1, 0, 5, 0, 1, 1, 1, 1, 5);  cyc("cbz_stall",  0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 5, 0, 1, 1, 0, 0, 5);  cyc("cbz_taken",  1, 1, 0, 0, 1, 0, 1);
    drv(1, 0, 0, 0, 0, 1, 0, 0, 0);  cyc("b_taken",    1, 1, 0, 0, 1, 0, 1);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  cyc("idle",       1, 1, 0, 0, 0, 0, 0);

    drv(1, 4, 0, 1, 0, 0, 1, 1, 4);  halt_req = 1'b1; cyc("halt_hz", 0, 0, 0, 1, 0, 0, 0);
    drv(1, 4, 0, 1, 0, 1, 1, 1, 4);  cyc("drain1_hz",  0, 1, 1, 1, 0, 0, 1);
    drv(1, 1, 2, 1, 1, 1, 0, 0, 0);  cyc("drain2",     0, 1, 1, 0, 0, 0, 1);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  halt_req = 1'b1; cyc("drain3", 0, 1, 1, 0, 0, 0, 1);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  cyc("halted",     0, 0, 0, 1, 0, 1, 0);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  halt_req = 1'b1; cyc("halted_hreq", 0, 0, 0, 1, 0, 1, 0);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  resume = 1'b1; cyc("resume", 0, 0, 0, 1, 0, 1, 0);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  resume = 1'b1; cyc("run_again", 1, 1, 0, 0, 0, 0, 0);

    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  halt_req = 1'b1; cyc("halt2", 1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  cyc("d2_1",       0, 1, 1, 0, 0, 0, 1);
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0);  reset_n = 1'b0; cyc("d2_rst", 1, 1, 0, 0, 0, 0, 0);
    drv(1, 3, 0, 1, 0, 0, 1, 1, 3);  cyc("post_rst_hz",0, 0, 0, 1, 0, 0, 0);
    drv(1, 3, 0, 1, 0, 0, 0, 0, 3);  cyc("post_rst",   1, 1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("final",      1, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
